// File: rtl/csr_arb_pkg.sv
// ---------------------------------------------------------------------------
// csr_arb_pkg
// Shared types and constants for the CSR MMIO arbiter.
//   t_arb_state  : arbiter FSM states
//   t_csr_req    : one latched CSR request (write flag, address, data, target)
//   TIMEOUT_DATA : read data returned when a completion never arrives
// The CSR_* widths size the request struct and are the defaults of the
// matching top-level parameters.
// ---------------------------------------------------------------------------
package csr_arb_pkg;

   localparam int CSR_ADDR_W = 20;
   localparam int CSR_DATA_W = 64;
   localparam int CSR_PF_W   = 3;
   localparam int CSR_VF_W   = 11;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } t_arb_state;

   typedef struct packed {
      logic                  write;
      logic [CSR_ADDR_W-1:0] addr;
      logic [CSR_DATA_W-1:0] wdata;
      logic [CSR_PF_W-1:0]   pf;
      logic [CSR_VF_W-1:0]   vf;
      logic                  vfa;
   } t_csr_req;

   localparam logic [CSR_DATA_W-1:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/csr_mmio_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// csr_rr_pick
// Combinational round-robin selector: finds the first asserted bit of
// 'valid' at or after index 'ptr', wrapping past N-1 back to 0.
//   valid : request vector
//   ptr   : starting index (highest priority this cycle)
//   idx   : selected index (0 when nothing is asserted)
//   any   : at least one bit of 'valid' is asserted
// ---------------------------------------------------------------------------
module csr_rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   // Scan from the farthest offset down to offset 0 so the candidate closest
   // to the pointer is the last one written and therefore wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         int               pos;
         logic [PTR_W-1:0] pos_idx;
         pos = int'(ptr) + i;
         if (pos >= N) pos = pos - N;
         pos_idx = PTR_W'(pos);
         if (valid[pos_idx]) begin
            idx = pos_idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/csr_mmio_arbiter.sv
// ---------------------------------------------------------------------------
// csr_mmio_arbiter
// Shares one downstream MMIO channel between NUM_REQ CSR requesters. One
// transaction is outstanding at a time so CSR ordering across functions is
// strict. Requests are granted round-robin, issued with a tag, and the
// write acceptance / read completion is returned to the granted requester.
// A watchdog ends a read with all-ones data and an error after TIMEOUT_CYC
// cycles without a matching completion.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_write/addr/wdata/pf/vf/vfa   packed per-requester request fields
//   rsp_valid             per-requester one-cycle response strobe
//   rsp_data, rsp_err     shared response bus, qualified by rsp_valid
//   mmio_valid/ready      downstream request handshake
//   mmio_write..mmio_vfa  granted request fields, mmio_tag its tag
//   cpl_valid/tag/data    downstream read completion
//   stale_cpl_cnt         saturating count of completions not accepted
// ---------------------------------------------------------------------------
module csr_mmio_arbiter
   import csr_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = CSR_ADDR_W,
   parameter int DATA_W      = CSR_DATA_W,
   parameter int PF_W        = CSR_PF_W,
   parameter int VF_W        = CSR_VF_W,
   parameter int TAG_W       = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   input  logic [NUM_REQ*PF_W-1:0]     req_pf,
   input  logic [NUM_REQ*VF_W-1:0]     req_vf,
   input  logic [NUM_REQ-1:0]          req_vfa,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rsp_err,
   output logic                        mmio_valid,
   input  logic                        mmio_ready,
   output logic                        mmio_write,
   output logic [ADDR_W-1:0]           mmio_addr,
   output logic [DATA_W-1:0]           mmio_wdata,
   output logic [PF_W-1:0]             mmio_pf,
   output logic [VF_W-1:0]             mmio_vf,
   output logic                        mmio_vfa,
   output logic [TAG_W-1:0]            mmio_tag,
   input  logic                        cpl_valid,
   input  logic [TAG_W-1:0]            cpl_tag,
   input  logic [DATA_W-1:0]           cpl_data,
   output logic [15:0]                 stale_cpl_cnt
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

   t_arb_state         state_q, state_d;
   t_csr_req           req_q;
   logic [PTR_W-1:0]   grant_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [TAG_W-1:0]   tag_q;
   logic [TMR_W-1:0]   timer_q;
   logic [DATA_W-1:0]  data_q;
   logic               err_q;
   logic [15:0]        stale_q;

   logic [PTR_W-1:0]   pick_idx;
   logic               pick_any;
   logic               cpl_hit;
   logic               timeout_hit;

   csr_rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .valid (req_valid),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // Next state and handshake strobes
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      req_ready   = '0;
      rsp_valid   = '0;
      mmio_valid  = 1'b0;
      cpl_hit     = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               req_ready[pick_idx] = 1'b1;
               state_d             = ISSUE;
            end
         end
         ISSUE: begin
            mmio_valid = 1'b1;
            if (mmio_ready) state_d = req_q.write ? RESP : WAIT;
         end
         WAIT: begin
            cpl_hit     = cpl_valid && (cpl_tag == tag_q);
            timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
            if (cpl_hit || timeout_hit) state_d = RESP;
         end
         RESP: begin
            rsp_valid[grant_q] = 1'b1;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Request latch, tag, pointer, watchdog and response data
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         tag_q   <= '0;
         timer_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_any) begin
                  req_q.write <= req_write[pick_idx];
                  req_q.addr  <= req_addr [pick_idx*ADDR_W +: ADDR_W];
                  req_q.wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                  req_q.pf    <= req_pf   [pick_idx*PF_W   +: PF_W];
                  req_q.vf    <= req_vf   [pick_idx*VF_W   +: VF_W];
                  req_q.vfa   <= req_vfa[pick_idx];
                  grant_q     <= pick_idx;
                  // Writes respond with zero data and no error.
                  data_q      <= '0;
                  err_q       <= 1'b0;
               end
            end
            ISSUE: begin
               if (mmio_ready && !req_q.write) timer_q <= '0;
            end
            WAIT: begin
               timer_q <= timer_q + 1'b1;
               // A completion in the timeout cycle still wins.
               if (cpl_hit) begin
                  data_q <= cpl_data;
                  err_q  <= 1'b0;
               end else if (timeout_hit) begin
                  data_q <= TIMEOUT_DATA;
                  err_q  <= 1'b1;
               end
            end
            RESP: begin
               tag_q <= tag_q + 1'b1;
               ptr_q <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Any completion not consumed as the awaited one is stale: wrong tag, or
   // arriving while no read is outstanding (including after a reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        stale_q <= '0;
      else if (cpl_valid && !cpl_hit && stale_q != 16'hFFFF) stale_q <= stale_q + 1'b1;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mmio_write    = req_q.write;
   assign mmio_addr     = req_q.addr;
   assign mmio_wdata    = req_q.wdata;
   assign mmio_pf       = req_q.pf;
   assign mmio_vf       = req_q.vf;
   assign mmio_vfa      = req_q.vfa;
   assign mmio_tag      = tag_q;
   assign rsp_data      = (state_q == RESP) ? data_q : '0;
   assign rsp_err       = (state_q == RESP) ? err_q  : 1'b0;
   assign stale_cpl_cnt = stale_q;

endmodule

// File: doc/csr_mmio_arbiter.md
Name: csr_mmio_arbiter

Overview:
Shares the single host MMIO request channel between NUM_REQ CSR requesters, such as per-function test agents targeting FME, PCIe, HE-LB, HSSI or VirtIO CSR space on a given PF/VF.
Grants one request at a time, round-robin. Issues it downstream with a tag and waits for the read completion or write acceptance. Returns the response to the granted requester.
A timeout watchdog guarantees forward progress when a function never completes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 20, CSR byte address width
DATA_W, 64, CSR data width
PF_W, 3, PF number width
VF_W, 11, VF number width
TAG_W, 8, downstream tag width
TIMEOUT_CYC, 1024, cycles to wait for a read completion before error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted (one-hot or zero)
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_pf  in  NUM_REQ*PF_W  target PF
req_vf  in  NUM_REQ*VF_W  target VF
req_vfa  in  NUM_REQ  VF active
rsp_valid  out  NUM_REQ  one-cycle response strobe
rsp_data  out  DATA_W  read data (shared bus, qualified by rsp_valid)
rsp_err  out  1  timeout error, qualified by rsp_valid
mmio_valid  out  1  downstream request valid
mmio_ready  in  1  downstream accept
mmio_write, mmio_addr, mmio_wdata, mmio_pf, mmio_vf, mmio_vfa  out  per field  granted request fields
mmio_tag  out  TAG_W  request tag
cpl_valid  in  1  read completion valid
cpl_tag  in  TAG_W  completion tag
cpl_data  in  DATA_W  completion data
stale_cpl_cnt  out  16  completions dropped for tag mismatch or arrival outside WAIT (saturating)

Behaviour:
- Reset values: all outputs 0; round-robin pointer = 0; tag = 0; FSM = IDLE.
- FSM states and transitions:
  - IDLE: pick the first asserted req_valid at or after the pointer, wrapping. Latch its fields into registers. Pulse req_ready[grant] for exactly that cycle. Go to ISSUE. With no req_valid, stay in IDLE.
  - ISSUE: mmio_valid=1 with registered fields and the current tag. Fields are stable while mmio_valid && !mmio_ready. On mmio_ready:
    - write: go to RESP.
    - read: go to WAIT, clear the timer.
  - WAIT: timer increments each cycle.
    - cpl_valid with cpl_tag==tag: capture cpl_data, err=0, go to RESP.
    - timer==TIMEOUT_CYC-1: data=all-ones, err=1, go to RESP.
    - Completion and timeout in the same cycle: the completion wins.
  - RESP: rsp_valid[grant]=1 for one cycle with rsp_data/rsp_err. Writes return data 0, err 0. Tag increments mod 2^TAG_W. Pointer = grant+1 mod NUM_REQ. Return to IDLE.
- Latency:
  - Minimum write: grant to rsp_valid = 3 cycles (IDLE, ISSUE with immediate ready, RESP).
  - Minimum read: 4 cycles.
- Any cpl_valid not accepted in WAIT increments stale_cpl_cnt, saturating at 0xFFFF. This covers a wrong tag or arrival in any other state.
- Requesters keep req_valid and their fields stable until req_ready. Dropping req_valid before grant is legal and causes no grant.
- Only one transaction is outstanding at a time by design, because CSR ordering across functions must be strict.
- rst_n assertion mid-transaction: immediate return to reset state with no response. A later completion carrying the old tag is counted stale.

Decomposition:
- Shared package csr_arb_pkg holds:
  - state enum t_arb_state {IDLE, ISSUE, WAIT, RESP};
  - struct t_csr_req {write, addr, wdata, pf, vf, vfa};
  - constant TIMEOUT_DATA = all-ones.
- One sub-module: csr_rr_pick. Combinational round-robin selection of the first asserted bit at or after the pointer; outputs a grant index and an any-valid flag.

Test Plan:
- Single read from requester 0 to addr 0x10008, pf=0. Completion tag 0, data 0xDEADBEEF after 5 cycles → rsp_valid[0] with data 0xDEADBEEF, err=0, next tag=1.
- Requesters 0–3 all request a write at once, mmio_ready always high → grant order 0,1,2,3, each rsp 3 cycles apart. Pointer ends at 0.
- Read to pf=3 (VirtIO, addr 0x20018) with no completion → rsp after TIMEOUT_CYC cycles in WAIT, data 0xFFFF_FFFF_FFFF_FFFF, err=1.
- Completion with tag 5 while expecting tag 2, then tag 2 with 0x1234 → stale_cpl_cnt=1, rsp data 0x1234.
- mmio_ready held low 10 cycles during ISSUE → mmio fields stable throughout. No second req_ready while stalled.
- rst_n low during WAIT, then the completion arrives after release → no rsp_valid, stale_cpl_cnt=1, tag=0.
